// File: rtl/branch_resolution_unit_pkg.sv
// Shared definitions for the EX-stage branch resolution unit:
// branch condition codes, datapath width and the squash FSM states.
package branch_resolution_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    SQ_IDLE   = 1'b0,
    SQ_SQUASH = 1'b1
  } squash_state_e;

endpackage

// File: rtl/branch_resolution_unit_if.sv
// EX-stage inputs and fetch-side redirect/predictor-update outputs of the
// branch resolution unit; master is the pipeline side, slave is the unit.
interface branch_resolution_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             instr_valid_ex_i;
  logic             stall_ex_i;
  logic             is_cond_branch_ex_i;
  logic             is_jal_ex_i;
  logic             is_jalr_ex_i;
  logic [2:0]       funct3_ex_i;
  logic [XLEN-1:0]  rs1_data_ex_i;
  logic [XLEN-1:0]  rs2_data_ex_i;
  logic [XLEN-1:0]  imm_ex_i;
  logic [XLEN-1:0]  pc_ex_i;
  logic             pred_taken_ex_i;
  logic [XLEN-1:0]  pred_target_ex_i;

  logic             branching_o;
  logic [XLEN-1:0]  branching_address_o;
  logic [XLEN-1:0]  pc_ex_o;
  logic             is_branch_instr_ex_o;
  logic             increment_counter_o;
  logic             decrement_counter_o;
  logic [XLEN-1:0]  link_value_o;
  logic [CNT_W-1:0] branch_count_o;
  logic [CNT_W-1:0] mispredict_count_o;

  modport master (
    output instr_valid_ex_i, stall_ex_i, is_cond_branch_ex_i, is_jal_ex_i,
           is_jalr_ex_i, funct3_ex_i, rs1_data_ex_i, rs2_data_ex_i, imm_ex_i,
           pc_ex_i, pred_taken_ex_i, pred_target_ex_i,
    input  branching_o, branching_address_o, pc_ex_o, is_branch_instr_ex_o,
           increment_counter_o, decrement_counter_o, link_value_o,
           branch_count_o, mispredict_count_o
  );

  modport slave (
    input  instr_valid_ex_i, stall_ex_i, is_cond_branch_ex_i, is_jal_ex_i,
           is_jalr_ex_i, funct3_ex_i, rs1_data_ex_i, rs2_data_ex_i, imm_ex_i,
           pc_ex_i, pred_taken_ex_i, pred_target_ex_i,
    output branching_o, branching_address_o, pc_ex_o, is_branch_instr_ex_o,
           increment_counter_o, decrement_counter_o, link_value_o,
           branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/branch_resolution_unit_branch_comparator.sv
// Combinational branch condition evaluation from the two forwarded operands;
// reserved condition codes resolve as not taken.
module branch_comparator
  import branch_resolution_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            cond_true_o
);

  // Evaluate the condition selected by funct3
  always_comb begin
    cond_true_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_true_o = (rs1_i == rs2_i);
      F3_BNE:  cond_true_o = (rs1_i != rs2_i);
      F3_BLT:  cond_true_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  cond_true_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: cond_true_o = (rs1_i <  rs2_i);
      F3_BGEU: cond_true_o = (rs1_i >= rs2_i);
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// EX-stage branch/jump resolver: same-cycle redirect and predictor update to
// fetch, one-instruction wrong-path squash, and branch/mispredict counters.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter bit ENABLE_PERF = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  branch_resolution_unit_if.slave bru
);

  squash_state_e    state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic            live_s;
  logic            cond_true_s;
  logic            taken_s;
  logic            mispredict_s;
  logic            branching_s;
  logic            is_cf_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] next_pc_s;

  branch_comparator #(.XLEN(XLEN)) u_cmp (
    .rs1_i       (bru.rs1_data_ex_i),
    .rs2_i       (bru.rs2_data_ex_i),
    .funct3_i    (bru.funct3_ex_i),
    .cond_true_o (cond_true_s)
  );

  // The squash state blocks the instruction that was already in ID when we redirected
  assign live_s  = bru.instr_valid_ex_i & ~bru.stall_ex_i & (state_q == SQ_IDLE);
  assign is_cf_s = bru.is_cond_branch_ex_i | bru.is_jal_ex_i | bru.is_jalr_ex_i;
  assign seq_pc_s = bru.pc_ex_i + {{(XLEN-3){1'b0}}, 3'd4};

  // Resolve direction, target and whether fetch went the wrong way
  always_comb begin
    taken_s      = bru.is_jal_ex_i | bru.is_jalr_ex_i |
                   (bru.is_cond_branch_ex_i & cond_true_s);
    target_s     = bru.pc_ex_i + bru.imm_ex_i;
    mispredict_s = 1'b0;
    if (bru.is_jalr_ex_i) begin
      target_s = (bru.rs1_data_ex_i + bru.imm_ex_i) & ~{{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      target_s = bru.pc_ex_i + bru.imm_ex_i;
    end
    if (taken_s) begin
      mispredict_s = ~bru.pred_taken_ex_i | (bru.pred_target_ex_i != target_s);
      next_pc_s    = target_s;
    end else begin
      mispredict_s = bru.pred_taken_ex_i;
      next_pc_s    = seq_pc_s;
    end
  end

  assign branching_s               = live_s & mispredict_s;
  assign bru.branching_o           = branching_s;
  assign bru.branching_address_o   = live_s ? next_pc_s : {XLEN{1'b0}};
  assign bru.pc_ex_o               = live_s ? bru.pc_ex_i : {XLEN{1'b0}};
  assign bru.link_value_o          = live_s ? seq_pc_s : {XLEN{1'b0}};
  assign bru.is_branch_instr_ex_o  = live_s & (bru.is_cond_branch_ex_i | bru.is_jal_ex_i);
  assign bru.increment_counter_o   = live_s & bru.is_cond_branch_ex_i & taken_s;
  assign bru.decrement_counter_o   = live_s & bru.is_cond_branch_ex_i & ~taken_s;
  assign bru.branch_count_o        = branch_cnt_q;
  assign bru.mispredict_count_o    = mispred_cnt_q;

  // Squash FSM next state: leave SQUASH once EX actually advances
  always_comb begin
    state_d = state_q;
    case (state_q)
      SQ_IDLE: begin
        if (branching_s) state_d = SQ_SQUASH;
        else             state_d = SQ_IDLE;
      end
      SQ_SQUASH: begin
        if (!bru.stall_ex_i) state_d = SQ_IDLE;
        else                 state_d = SQ_SQUASH;
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  // Performance counter next values, wrapping naturally at 2^CNT_W
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ENABLE_PERF) begin
      branch_cnt_d  = branch_cnt_q  + {{(CNT_W-1){1'b0}}, (live_s & is_cf_s)};
      mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, branching_s};
    end else begin
      branch_cnt_d  = {CNT_W{1'b0}};
      mispred_cnt_d = {CNT_W{1'b0}};
    end
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= SQ_IDLE;
      branch_cnt_q  <= {CNT_W{1'b0}};
      mispred_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_branch_resolution_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolution_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolution_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .ENABLE_PERF(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bru    (bus)
  );

  typedef struct {
    logic        br;
    logic [31:0] addr;
    logic [31:0] link;
    logic [31:0] pc;
    logic        isb;
    logic        inc;
    logic        dec;
    logic        cf;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_squash = 1'b0;
  logic [31:0] m_bc = 32'd0;
  logic [31:0] m_mc = 32'd0;
  exp_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What fetch must see, derived from the ISA rules and the squash flag
  function automatic exp_t model_eval();
    exp_t r;
    logic live, ct, taken, redirect;
    logic [31:0] tgt, a, b, pc, imm;
    a = bus.rs1_data_ex_i; b = bus.rs2_data_ex_i; pc = bus.pc_ex_i; imm = bus.imm_ex_i;
    live = bus.instr_valid_ex_i && !bus.stall_ex_i && !m_squash;
    case (bus.funct3_ex_i)
      3'd0: ct = (a == b);
      3'd1: ct = (a != b);
      3'd4: ct = ($signed(a) <  $signed(b));
      3'd5: ct = ($signed(a) >= $signed(b));
      3'd6: ct = (a <  b);
      3'd7: ct = (a >= b);
      default: ct = 1'b0;
    endcase
    taken = bus.is_jal_ex_i || bus.is_jalr_ex_i || (bus.is_cond_branch_ex_i && ct);
    tgt = bus.is_jalr_ex_i ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    redirect = taken ? (!bus.pred_taken_ex_i || bus.pred_target_ex_i != tgt) : bus.pred_taken_ex_i;
    r.br   = live && redirect;
    r.addr = live ? (taken ? tgt : pc + 32'd4) : 32'd0;
    r.link = live ? pc + 32'd4 : 32'd0;
    r.pc   = live ? pc : 32'd0;
    r.isb  = live && (bus.is_cond_branch_ex_i || bus.is_jal_ex_i);
    r.inc  = live && bus.is_cond_branch_ex_i && taken;
    r.dec  = live && bus.is_cond_branch_ex_i && !taken;
    r.cf   = live && (bus.is_cond_branch_ex_i || bus.is_jal_ex_i || bus.is_jalr_ex_i);
    return r;
  endfunction

  // Compare every output on the falling edge, advance the model on the rising edge
  always begin
    @(negedge clk);
    if (!rst_n) begin
      m_squash = 1'b0; m_bc = 32'd0; m_mc = 32'd0;
    end
    e = model_eval();
    chk("m_branching", {31'd0, bus.branching_o}, {31'd0, e.br});
    chk("m_address",   bus.branching_address_o, e.addr);
    chk("m_link",      bus.link_value_o, e.link);
    chk("m_pc",        bus.pc_ex_o, e.pc);
    chk("m_is_branch", {31'd0, bus.is_branch_instr_ex_o}, {31'd0, e.isb});
    chk("m_inc",       {31'd0, bus.increment_counter_o}, {31'd0, e.inc});
    chk("m_dec",       {31'd0, bus.decrement_counter_o}, {31'd0, e.dec});
    chk("m_bcount",    bus.branch_count_o, m_bc);
    chk("m_mcount",    bus.mispredict_count_o, m_mc);
    @(posedge clk);
    if (rst_n) begin
      m_bc = m_bc + {31'd0, e.cf};
      m_mc = m_mc + {31'd0, e.br};
      if (m_squash) m_squash = bus.stall_ex_i;
      else          m_squash = e.br;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 cond branch, 1 JAL, 2 JALR, 3 other
  task automatic set_instr(input bit v, input bit st, input int kind, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] pc, input bit pt, input logic [31:0] ptg);
    bus.instr_valid_ex_i    = v;
    bus.stall_ex_i          = st;
    bus.is_cond_branch_ex_i = (kind == 0);
    bus.is_jal_ex_i         = (kind == 1);
    bus.is_jalr_ex_i        = (kind == 2);
    bus.funct3_ex_i         = f3;
    bus.rs1_data_ex_i       = a;
    bus.rs2_data_ex_i       = b;
    bus.imm_ex_i            = imm;
    bus.pc_ex_i             = pc;
    bus.pred_taken_ex_i     = pt;
    bus.pred_target_ex_i    = ptg;
  endtask

  task automatic idle();
    set_instr(1'b0, 1'b0, 3, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    logic [31:0] a, b, imm, pc, tgt;
    idle();
    #2;
    do_reset();

    // 1: BEQ mispredicted not-taken, then the next instruction is squashed
    set_instr(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 0, 32'd0);
    @(negedge clk);
    chk("t1_br",   {31'd0, bus.branching_o}, 32'd1);
    chk("t1_addr", bus.branching_address_o, 32'h120);
    chk("t1_inc",  {31'd0, bus.increment_counter_o}, 32'd1);
    chk("t1_isb",  {31'd0, bus.is_branch_instr_ex_o}, 32'd1);
    step();
    set_instr(1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h8, 32'h104, 0, 32'd0);
    @(negedge clk);
    chk("t1_sq_br",  {31'd0, bus.branching_o}, 32'd0);
    chk("t1_sq_inc", {31'd0, bus.increment_counter_o}, 32'd0);
    chk("t1_sq_isb", {31'd0, bus.is_branch_instr_ex_o}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t1_bc", bus.branch_count_o, 32'd1);
    chk("t1_mc", bus.mispredict_count_o, 32'd1);

    // 2: BNE predicted taken but falls through
    do_reset();
    set_instr(1, 0, 0, 3'b001, 32'd7, 32'd7, 32'h20, 32'h100, 1, 32'h120);
    @(negedge clk);
    chk("t2_br",   {31'd0, bus.branching_o}, 32'd1);
    chk("t2_addr", bus.branching_address_o, 32'h104);
    chk("t2_dec",  {31'd0, bus.decrement_counter_o}, 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("t2_mc", bus.mispredict_count_o, 32'd1);

    // 3: signed BLT correctly predicted taken
    do_reset();
    set_instr(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200, 1, 32'h210);
    @(negedge clk);
    chk("t3_br",  {31'd0, bus.branching_o}, 32'd0);
    chk("t3_inc", {31'd0, bus.increment_counter_o}, 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("t3_bc", bus.branch_count_o, 32'd1);
    chk("t3_mc", bus.mispredict_count_o, 32'd0);

    // 4: unsigned vs signed compare of the same operands, reserved funct3
    step();
    set_instr(1, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h300, 1, 32'h308);
    @(negedge clk);
    chk("t4_bgeu_inc", {31'd0, bus.increment_counter_o}, 32'd1);
    chk("t4_bgeu_br",  {31'd0, bus.branching_o}, 32'd0);
    step();
    set_instr(1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h304, 0, 32'd0);
    @(negedge clk);
    chk("t4_bge_dec", {31'd0, bus.decrement_counter_o}, 32'd1);
    step();
    set_instr(1, 0, 0, 3'b010, 32'd3, 32'd3, 32'h8, 32'h308, 0, 32'd0);
    @(negedge clk);
    chk("t4_f010_dec", {31'd0, bus.decrement_counter_o}, 32'd1);
    chk("t4_f010_inc", {31'd0, bus.increment_counter_o}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t4_bc", bus.branch_count_o, 32'd4);

    // 5: JALR held by a 3-cycle stall resolves exactly once on release
    do_reset();
    set_instr(1, 1, 2, 3'b000, 32'h203, 32'd0, 32'd4, 32'h40, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_br", {31'd0, bus.branching_o}, 32'd0);
      step();
    end
    bus.stall_ex_i = 1'b0;
    @(negedge clk);
    chk("t5_br",   {31'd0, bus.branching_o}, 32'd1);
    chk("t5_addr", bus.branching_address_o, 32'h206);
    chk("t5_link", bus.link_value_o, 32'h44);
    chk("t5_isb",  {31'd0, bus.is_branch_instr_ex_o}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t5_bc", bus.branch_count_o, 32'd1);
    chk("t5_mc", bus.mispredict_count_o, 32'd1);

    // 6: reset while squashing, then a BEQ resolves normally
    do_reset();
    set_instr(1, 0, 0, 3'b000, 32'd3, 32'd3, 32'h40, 32'h500, 0, 32'd0);
    @(negedge clk);
    chk("t6_br0", {31'd0, bus.branching_o}, 32'd1);
    step();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    set_instr(1, 0, 0, 3'b000, 32'd3, 32'd3, 32'h40, 32'h500, 0, 32'd0);
    @(negedge clk);
    chk("t6_bc",   bus.branch_count_o, 32'd0);
    chk("t6_mc",   bus.mispredict_count_o, 32'd0);
    chk("t6_br",   {31'd0, bus.branching_o}, 32'd1);
    chk("t6_addr", bus.branching_address_o, 32'h540);

    // Randomized traffic, stalled instructions mostly held in place
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
      end
      if (!(bus.stall_ex_i && bus.instr_valid_ex_i) || $urandom_range(0, 3) == 0) begin
        k   = $urandom_range(0, 3);
        a   = pick_op();
        b   = ($urandom_range(0, 2) == 0) ? a : pick_op();
        imm = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom)};
        pc  = {$urandom, 2'b00} & 32'h0000_FFFC;
        tgt = (k == 2) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        set_instr($urandom_range(0, 6) != 0, 1'b0, k, 3'($urandom), a, b, imm, pc,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? tgt : $urandom);
      end
      bus.stall_ex_i = ($urandom_range(0, 4) == 0);
    end
    step();
    idle();
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
